// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// sequencing each access through a fixed-latency memory and returning completion/data.
module mem_port_arbiter #(
  parameter int unsigned ADDR_BITS     = 64,
  parameter int unsigned DATA_BITS     = 64,
  parameter int unsigned MEM_LATENCY   = 2,
  parameter int unsigned DATA_PRIORITY = 1,
  parameter int unsigned STARVE_LIMIT  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [ADDR_BITS-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_valid,
  output logic [DATA_BITS-1:0] if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [DATA_BITS-1:0] d_wdata,
  output logic                 d_gnt,
  output logic                 d_valid,
  output logic [DATA_BITS-1:0] d_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 busy
);

  localparam int unsigned WCW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic            HI_D      = (DATA_PRIORITY != 0);
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);
  localparam logic [SCW-1:0]  SLIM      = SCW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state, state_nx;
  logic           arb, contested, take, win_d;
  logic           cur_d, cur_we;
  logic [WCW-1:0] wcnt;
  logic [SCW-1:0] lost;

  always_comb begin
    arb       = (state == IDLE) || (state == DONE);
    contested = if_req && d_req;
    take      = arb && (if_req || d_req);
    win_d     = d_req;
    // lost counts consecutive contested losses of the non-priority side only
    if (contested) win_d = (lost >= SLIM) ? ~HI_D : HI_D;
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = ISSUE;
      ISSUE:   state_nx = (MEM_LATENCY > 1) ? WAIT : DONE;
      WAIT:    if (wcnt == WAIT_LAST) state_nx = DONE;
      DONE:    state_nx = take ? ISSUE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur_d     <= 1'b0;
      cur_we    <= 1'b0;
      wcnt      <= '0;
      lost      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= (state == WAIT) ? wcnt + WCW'(1) : '0;
      if (take) begin
        cur_d     <= win_d;
        cur_we    <= win_d && d_we;
        mem_addr  <= win_d ? d_addr : if_addr;
        mem_wdata <= (win_d && d_we) ? d_wdata : '0;
        if (win_d != HI_D) lost <= '0;
        else if (contested && lost < SLIM) lost <= lost + SCW'(1);
      end
      // read data is captured on the edge that enters DONE
      if (state != DONE && state_nx == DONE && !cur_we) begin
        if (cur_d) d_rdata  <= mem_rdata;
        else       if_rdata <= mem_rdata;
      end
    end
  end

  assign if_gnt   = (state == ISSUE) && !cur_d;
  assign d_gnt    = (state == ISSUE) &&  cur_d;
  assign if_valid = (state == DONE)  && !cur_d;
  assign d_valid  = (state == DONE)  &&  cur_d;
  assign mem_en   = (state == ISSUE);
  assign mem_we   = (state == ISSUE) && cur_we;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter, plus a directed run of a
// single-cycle-latency, fetch-priority instance.
module tb_mem_port_arbiter;
  localparam int ML = 2;
  localparam int SL = 2;
  localparam bit HI_D = 1'b1;
  localparam logic [63:0] XK = 64'hC3C3_0000_5A5A_0F0F;

  logic clock = 1'b0, reset = 1'b0;
  always #5 clock = ~clock;

  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [63:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy;
  logic [63:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  logic        i1_req = 0, d1_req = 0;
  logic [63:0] i1_addr = 64'h40, d1_addr = 64'h80;
  logic        i1_gnt, i1_valid, d1_gnt, d1_valid, m1_en, m1_we, busy1;
  logic [63:0] i1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;
  assign m1_rdata = m1_addr ^ XK;

  mem_port_arbiter #(.ADDR_BITS(64), .DATA_BITS(64), .MEM_LATENCY(ML),
                     .DATA_PRIORITY(1), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));

  mem_port_arbiter #(.ADDR_BITS(64), .DATA_BITS(64), .MEM_LATENCY(1),
                     .DATA_PRIORITY(0), .STARVE_LIMIT(1)) dut1 (
    .clock(clock), .reset(reset),
    .if_req(i1_req), .if_addr(i1_addr), .if_gnt(i1_gnt), .if_valid(i1_valid), .if_rdata(i1_rdata),
    .d_req(d1_req), .d_we(1'b0), .d_addr(d1_addr), .d_wdata(64'h0),
    .d_gnt(d1_gnt), .d_valid(d1_valid), .d_rdata(d1_rdata),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .busy(busy1));

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0]};
  endfunction

  // memory behind dut: stores land at issue, read data presented one cycle later
  logic [63:0] tbmem [logic [63:0]];
  always @(posedge clock) begin
    if (mem_en && mem_we) tbmem[mem_addr] = mem_wdata;
    if (mem_en) mem_rdata <= tbmem.exists(mem_addr) ? tbmem[mem_addr] : init_val(mem_addr);
  end

  // reference model: one access at a time, port free again at the end of its done cycle
  typedef struct {int cyc; bit is_d; bit we; logic [63:0] addr; logic [63:0] wdata; logic [63:0] rd;} ev_t;
  ev_t gq[$], vq[$];
  logic [63:0] refmem [logic [63:0]];
  int  edge_cnt = 0, free_from = 0, cur_g = -1, cur_v = -1, lost = 0;
  bit  model_on = 0, stim_on = 0;
  logic [63:0] i_last = '0, d_last = '0;

  always @(posedge clock) begin
    ev_t ev;
    bit contested, win_d;
    edge_cnt++;
    if (model_on && reset && edge_cnt >= free_from && (if_req || d_req)) begin
      contested = if_req && d_req;
      win_d = contested ? ((lost >= SL) ? !HI_D : HI_D) : d_req;
      if (win_d != HI_D) lost = 0;
      else if (contested) lost++;
      ev.cyc   = edge_cnt + 1;
      ev.is_d  = win_d;
      ev.we    = win_d && d_we;
      ev.addr  = win_d ? d_addr : if_addr;
      ev.wdata = ev.we ? d_wdata : 64'h0;
      if (ev.we) refmem[ev.addr] = ev.wdata;
      else begin
        logic [63:0] v;
        v = refmem.exists(ev.addr) ? refmem[ev.addr] : init_val(ev.addr);
        if (win_d) d_last = v; else i_last = v;
      end
      ev.rd = win_d ? d_last : i_last;
      gq.push_back(ev);
      ev.cyc = edge_cnt + 1 + ML;
      vq.push_back(ev);
      cur_g = edge_cnt + 1;
      cur_v = edge_cnt + 1 + ML;
      free_from = cur_v;
    end
  end

  task automatic flush_model();
    gq.delete(); vq.delete();
    free_from = 0; cur_g = -1; cur_v = -1; lost = 0;
    i_last = '0; d_last = '0;
  endtask

  // random requesters: hold until grant, then drop and scramble address
  always @(negedge clock) begin
    if (if_req && if_gnt) begin
      if_req = 0; if_addr = {$urandom, $urandom};
    end else if (!if_req && stim_on && $urandom_range(3) != 0) begin
      if_req = 1; if_addr = 64'($urandom_range(15)) << 3;
    end
    if (d_req && d_gnt) begin
      d_req = 0; d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom}; d_we = $urandom_range(1);
    end else if (!d_req && stim_on && $urandom_range(3) != 0) begin
      d_req = 1; d_we = ($urandom_range(2) == 0);
      d_addr = 64'($urandom_range(15)) << 3; d_wdata = {$urandom, $urandom};
    end
  end

  // monitor
  always @(negedge clock) begin
    int c;
    ev_t e;
    c = edge_cnt + 1;
    if (model_on && reset) begin
      check("gnt_exclusive", 64'(if_gnt && d_gnt), 64'h0);
      check("valid_exclusive", 64'(if_valid && d_valid), 64'h0);
      check("busy", 64'(busy), 64'(c >= cur_g && c <= cur_v));
      check("mem_en", 64'(mem_en), 64'(c == cur_g));
      if (if_gnt || d_gnt) begin
        if (gq.size() == 0) check("unexpected_gnt", 64'(c), 64'hFFFF_FFFF);
        else begin
          e = gq.pop_front();
          check("gnt_cycle", 64'(c), 64'(e.cyc));
          check("gnt_side", 64'(d_gnt), 64'(e.is_d));
          check("mem_addr", mem_addr, e.addr);
          check("mem_we", 64'(mem_we), 64'(e.we));
          check("mem_wdata", mem_wdata, e.wdata);
        end
      end else if (gq.size() > 0 && gq[0].cyc <= c) begin
        e = gq.pop_front();
        check("missing_gnt", 64'(c), 64'(e.cyc + 1000));
      end
      if (if_valid || d_valid) begin
        if (vq.size() == 0) check("unexpected_valid", 64'(c), 64'hFFFF_FFFF);
        else begin
          e = vq.pop_front();
          check("valid_cycle", 64'(c), 64'(e.cyc));
          check("valid_side", 64'(d_valid), 64'(e.is_d));
          if (e.is_d) check("d_rdata", d_rdata, e.rd);
          else        check("if_rdata", if_rdata, e.rd);
        end
      end else if (vq.size() > 0 && vq[0].cyc <= c) begin
        e = vq.pop_front();
        check("missing_valid", 64'(c), 64'(e.cyc + 1000));
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy}), 64'h0);
    check({tag, "_mem_addr"}, mem_addr, 64'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'h0);
    check({tag, "_if_rdata"}, if_rdata, 64'h0);
    check({tag, "_d_rdata"}, d_rdata, 64'h0);
  endtask

  task automatic drain(input string tag);
    int n;
    stim_on = 0;
    n = 0;
    while ((if_req || d_req || gq.size() != 0 || vq.size() != 0 || busy) && n < 200) begin
      @(negedge clock); n++;
    end
    check({tag, "_drain_timeout"}, 64'(n >= 200), 64'h0);
  endtask

  initial begin
    int n, vcount;
    #2 check_zero("reset");
    repeat (2) @(negedge clock);
    reset = 1; model_on = 1; stim_on = 1;
    repeat (400) @(negedge clock);
    drain("rand1");

    // reset during the wait of a fetch
    if_req = 1; if_addr = 64'h40;
    n = 0;
    do begin @(negedge clock); n++; end while (!if_gnt && n < 10);
    check("abort_gnt_seen", 64'(if_gnt), 64'h1);
    @(negedge clock);
    reset = 0; model_on = 0; flush_model();
    #1 check_zero("abort");
    repeat (2) @(negedge clock);
    reset = 1; model_on = 1;
    vcount = 0;
    repeat (6) begin @(negedge clock); vcount += int'(if_valid); end
    check("no_valid_after_abort", 64'(vcount), 64'h0);
    stim_on = 1;
    repeat (300) @(negedge clock);
    drain("rand2");

    // latency-1 instance, fetch priority, both sides held
    @(negedge clock);
    i1_req = 1; d1_req = 1;
    for (int c = 1; c <= 12; c++) begin
      int k;
      bit sd, odd;
      @(negedge clock);
      odd = (c % 2) == 1;
      k = odd ? (c - 1) / 2 : (c - 2) / 2;
      sd = (k % 2) == 1;
      check("l1_ctl", 64'({i1_gnt, d1_gnt, i1_valid, d1_valid, m1_en}),
            odd ? 64'({!sd, sd, 1'b0, 1'b0, 1'b1}) : 64'({1'b0, 1'b0, !sd, sd, 1'b0}));
      check("l1_busy", 64'(busy1), 64'h1);
      check("l1_we", 64'(m1_we), 64'h0);
      if (!odd && !sd) check("l1_if_rdata", i1_rdata, 64'h40 ^ XK);
      if (!odd &&  sd) check("l1_d_rdata", d1_rdata, 64'h80 ^ XK);
      if (c == 12) begin i1_req = 0; d1_req = 0; end
    end
    repeat (2) @(negedge clock);
    check("l1_idle", 64'(busy1), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
